data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-side responder for the single-cycle RISC-V core. It sits on the core's data port (MemWrite, ALUResult, WriteData, ReadData) and serves word reads and writes to a local RAM. It also provides memory-mapped I/O:

- a console byte FIFO, drained over a valid/ready stream;
- a free-running 32-bit cycle counter.

Reads are combinational so the single-cycle core completes loads in one cycle. Writes commit on the rising clock edge.

## Interface

Parameters:

- RAM_WORDS, 64: number of 32-bit RAM words; power of two, at least 4.
- FIFO_DEPTH, 8: console FIFO entries; power of two, at least 2.

Ports:

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- MemWrite  in  1  write strobe from the core.
- ALUResult  in  32  byte address from the core; bits [1:0] ignored (word access only).
- WriteData  in  32  store data from the core.
- ReadData  out  32  load data, combinational from ALUResult and current state.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  downstream accepts the byte when high together with tx_valid.

## Operation

Address decode:

- ALUResult[31]=0 selects RAM. Word index is ALUResult[log2(RAM_WORDS)+1:2].
  - RAM reads and writes apply only when ALUResult[30:log2(RAM_WORDS)+2] is zero.
  - Any other address in this half reads 0; writes to it are ignored.
- ALUResult[31]=1 selects MMIO, decoded on ALUResult[3:2] with all other bits don't-care:
  - 0x0 CONSOLE:
    - Write pushes WriteData[7:0].
    - Read returns 0.
  - 0x1 STATUS:
    - Read returns {29'b0, ovf, empty, full}.
    - Writing 1 to WriteData[2] clears ovf; other bits are read-only.
  - 0x2 CYCLE:
    - Read returns the counter.
    - Write loads WriteData.
  - 0x3 LEVEL:
    - Read returns the FIFO entry count, zero-extended.
    - Writes are ignored.
- A write occurs only when MemWrite=1.

RAM:

- Not reset; contents are X until written.
- Read is asynchronous.

Console FIFO:

- Circular buffer with a read pointer, a write pointer and a count register of width log2(FIFO_DEPTH)+1.
- full = (count==FIFO_DEPTH); empty = (count==0).
- pop = tx_valid & tx_ready.
- push request = CONSOLE write.
  - Accepted if !full, or if full and pop happens in the same cycle.
  - A rejected push drops the byte and sets ovf (sticky).
- Simultaneous accepted push and pop: count unchanged; both pointers advance.
- Pointers wrap modulo FIFO_DEPTH.
- tx_valid = !empty, taken from registered count. There is no push-to-output bypass.
- tx_data = storage[rd_ptr]. It stays stable while tx_valid=1 and tx_ready=0.
- ovf set and clear in the same cycle: set wins.

Cycle counter:

- Increments by 1 every cycle; wraps from 0xFFFFFFFF to 0.
- A CYCLE write loads WriteData instead of incrementing that cycle.

## Timing

- Reset values:
  - count=0, pointers=0, storage=0, ovf=0, cycle=0.
  - Hence tx_valid=0 and tx_data=0x00.
  - ReadData of STATUS is 0x2.
- ReadData has zero latency: combinational in the same cycle as ALUResult.
- A store becomes visible on the cycle after its edge. A load in the same cycle as a store to the same address returns the old value.
- FIFO timing:
  - Push at edge N gives tx_valid=1 from cycle N+1.
  - A pop at edge N shows the next head, or tx_valid=0, from cycle N+1.
  - LEVEL and STATUS reflect state after the most recent edge.
- CYCLE write of V at edge N: a read in cycle N+1 returns V, then V+1 in cycle N+2.
- Reset asserted mid-operation:
  - All registers clear immediately (asynchronous): FIFO empties, tx_valid drops, pending bytes are lost, the counter goes to 0.
  - RAM is unaffected.
  - Release is synchronized externally; the first counter increment is on the first edge with reset=1.

## Test plan

- RAM: store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010 gives 0xDEADBEEF. Load 0x0000_0200 (out of range for 64 words) gives 0. Store to 0x0000_0200 leaves all RAM words unchanged.
- FIFO fill/overflow: with tx_ready=0, write 0x41..0x49 (nine bytes) to 0x8000_0000.
  - LEVEL reads 8; STATUS reads 0x5.
  - Raise tx_ready: bytes 0x41..0x48 appear in order, one per cycle, then tx_valid=0.
  - Write 0x4 to STATUS: STATUS reads 0x2.
- Full push+pop: FIFO full, tx_ready=1 and CONSOLE write 0x5A in the same cycle.
  - Push accepted; ovf stays 0; LEVEL stays 8.
  - 0x5A emerges after the 7 older bytes.
- Backpressure: toggle tx_ready randomly. tx_data must hold while tx_valid=1 and tx_ready=0, with no byte lost or duplicated across a pointer wrap (20 bytes through depth 8).
- Counter: write 0xFFFFFFFE to 0x8000_0008. The next three reads return 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- Reset mid-stream: with 3 bytes queued, pulse reset low between edges.
  - tx_valid falls immediately; LEVEL=0; CYCLE=0.
  - Previously written RAM data is still readable.

Source files
------------

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-port responder: word RAM, console byte FIFO, cycle counter
module data_mem_responder #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = FW + 1;

    logic [31:0]   ram [RAM_WORDS];
    logic [7:0]    storage [FIFO_DEPTH];
    logic [FW-1:0] rd_ptr;
    logic [FW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          ovf;
    logic [31:0]   cycle;

    logic          unused_addr;
    logic          mmio;
    logic [1:0]    mreg;
    logic          ram_hit;
    logic [AW-1:0] ram_idx;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push_req;
    logic          push_ok;
    logic          ovf_clr;
    logic          cycle_wr;

    // Word access only: the byte offset bits carry no meaning here.
    assign unused_addr = ^ALUResult[1:0];

    assign mmio     = ALUResult[31];
    assign mreg     = ALUResult[3:2];
    assign ram_hit  = !mmio && (ALUResult[30:AW+2] == '0);
    assign ram_idx  = ALUResult[AW+1:2];

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign tx_valid = !empty;
    assign tx_data  = storage[rd_ptr];
    assign pop      = tx_valid && tx_ready;

    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign push_req = MemWrite && mmio && (mreg == 2'd0);
    assign push_ok  = push_req && (!full || pop);
    assign ovf_clr  = MemWrite && mmio && (mreg == 2'd1) && WriteData[2];
    assign cycle_wr = MemWrite && mmio && (mreg == 2'd2);

    always_comb begin
        ReadData = '0;
        if (!mmio) begin
            if (ram_hit)
                ReadData = ram[ram_idx];
        end else begin
            case (mreg)
                2'd1:    ReadData = {29'b0, ovf, empty, full};
                2'd2:    ReadData = cycle;
                2'd3:    ReadData = 32'(count);
                default: ReadData = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (MemWrite && ram_hit)
            ram[ram_idx] <= WriteData;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            cycle  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                storage[i] <= '0;
        end else begin
            if (push_ok) begin
                storage[wr_ptr] <= WriteData[7:0];
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A dropped byte in the same cycle as a clear keeps the flag set.
            if (push_req && !push_ok)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
            if (cycle_wr)
                cycle <= WriteData;
            else
                cycle <= cycle + 32'd1;
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;
    localparam int RW = 64;
    localparam int FD = 8;
    localparam logic [31:0] A_CON = 32'h8000_0000;
    localparam logic [31:0] A_STA = 32'h8000_0004;
    localparam logic [31:0] A_CYC = 32'h8000_0008;
    localparam logic [31:0] A_LVL = 32'h8000_000C;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] ALUResult = '0;
    logic [31:0] WriteData = '0;
    logic        tx_ready = 1'b0;
    logic [31:0] ReadData;
    logic [7:0]  tx_data;
    logic        tx_valid;

    data_mem_responder #(.RAM_WORDS(RW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
        .WriteData(WriteData), .ReadData(ReadData), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0]  ram_m [int];
    byte unsigned q[$];
    byte unsigned rx[$];
    byte unsigned sent[$];
    bit           ovf_m = 1'b0;
    logic [31:0]  cyc_m = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns 0 when the addressed RAM word has never been written.
    function automatic bit exp_read(input logic [31:0] a, output logic [31:0] v);
        v = '0;
        if (a < 32'h8000_0000) begin
            if (a >= 32'(RW * 4))
                return 1'b1;
            if (!ram_m.exists(int'(a >> 2)))
                return 1'b0;
            v = ram_m[int'(a >> 2)];
            return 1'b1;
        end
        case (a[3:2])
            2'd0: v = 32'd0;
            2'd1: v = {29'b0, ovf_m, q.size() == 0, q.size() == FD};
            2'd2: v = cyc_m;
            default: v = 32'(q.size());
        endcase
        return 1'b1;
    endfunction

    // One clock cycle: drive, check combinational outputs, clock, advance the model.
    task automatic cyc(input bit we, input logic [31:0] a, input logic [31:0] wd, input bit rdy,
                       input bit has_exp = 1'b0, input logic [31:0] xexp = '0, input string tag = "");
        logic [31:0] e;
        bit pop, preq, acc;
        MemWrite = we; ALUResult = a; WriteData = wd; tx_ready = rdy;
        #1;
        if (exp_read(a, e))
            chk("ReadData", ReadData, e);
        if (has_exp)
            chk(tag, ReadData, xexp);
        chk("tx_valid", 32'(tx_valid), 32'(q.size() != 0));
        if (q.size() != 0)
            chk("tx_data", 32'(tx_data), 32'(q[0]));
        pop = (q.size() != 0) && rdy;
        if (pop)
            rx.push_back(tx_data);
        @(posedge clk);
        preq = we && a[31] && (a[3:2] == 2'd0);
        acc  = preq && ((q.size() < FD) || pop);
        if (pop)
            void'(q.pop_front());
        if (acc)
            q.push_back(wd[7:0]);
        if (preq && !acc)
            ovf_m = 1'b1;
        else if (we && a[31] && (a[3:2] == 2'd1) && wd[2])
            ovf_m = 1'b0;
        if (we && a[31] && (a[3:2] == 2'd2))
            cyc_m = wd;
        else
            cyc_m = cyc_m + 32'd1;
        if (we && (a < 32'(RW * 4)))
            ram_m[int'(a >> 2)] = wd;
        @(negedge clk);
    endtask

    initial begin
        byte unsigned b;
        bit we, rdy;
        int budget;

        @(negedge clk);
        ALUResult = A_STA; #1; chk("reset_status", ReadData, 32'h2);
        ALUResult = A_LVL; #1; chk("reset_level", ReadData, 32'h0);
        ALUResult = A_CYC; #1; chk("reset_cycle", ReadData, 32'h0);
        chk("reset_tx_valid", 32'(tx_valid), 32'h0);
        chk("reset_tx_data", 32'(tx_data), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        cyc(1, 32'h10, 32'hDEAD_BEEF, 0);
        cyc(0, 32'h10, 0, 0, 1, 32'hDEAD_BEEF, "ram_load");
        cyc(0, 32'h200, 0, 0, 1, 32'h0, "ram_oob_load");
        for (int i = 0; i < RW; i++)
            cyc(1, 32'(i * 4), $urandom, 0);
        cyc(1, 32'h10, 32'hCAFE_F00D, 0);
        cyc(1, 32'h200, 32'h1234_5678, 0);
        for (int i = 0; i < 4; i++)
            cyc(0, ($urandom & 32'h7FFF_FFFF) | 32'h100, 0, 0);
        for (int i = 0; i < RW; i++)
            cyc(0, 32'(i * 4), 0, 0);

        rx.delete();
        for (int i = 0; i < 9; i++)
            cyc(1, A_CON, 32'(8'h41 + i), 0);
        cyc(0, A_LVL, 0, 0, 1, 32'd8, "level_full");
        cyc(0, A_STA, 0, 0, 1, 32'h5, "status_full_ovf");
        for (int i = 0; i < 9; i++)
            cyc(0, A_LVL, 0, 1);
        chk("drain_count", 32'(rx.size()), 32'd8);
        for (int i = 0; i < rx.size() && i < 8; i++)
            chk("drain_byte", 32'(rx[i]), 32'(8'h41 + i));
        cyc(1, A_STA, 32'h4, 0);
        cyc(0, A_STA, 0, 0, 1, 32'h2, "status_ovf_clr");

        for (int i = 0; i < FD; i++)
            cyc(1, A_CON, 32'(8'h61 + i), 0);
        rx.delete();
        cyc(1, A_CON, 32'h5A, 1);
        cyc(0, A_STA, 0, 0, 1, 32'h1, "status_full_pushpop");
        cyc(0, A_LVL, 0, 0, 1, 32'd8, "level_pushpop");
        for (int i = 0; i < 9; i++)
            cyc(0, A_LVL, 0, 1);
        chk("pushpop_count", 32'(rx.size()), 32'd9);
        if (rx.size() == 9)
            chk("pushpop_last", 32'(rx[8]), 32'h5A);

        rx.delete();
        sent.delete();
        budget = 0;
        while ((rx.size() < 20) && (budget < 500)) begin
            we  = (sent.size() < 20) && (q.size() < FD) && ($urandom_range(0, 1) == 1);
            rdy = ($urandom_range(0, 2) != 0);
            if (we) begin
                b = 8'($urandom);
                sent.push_back(b);
                cyc(1, A_CON, 32'(b), rdy);
            end else begin
                cyc(0, A_LVL, 0, rdy);
            end
            budget++;
        end
        chk("bp_count", 32'(rx.size()), 32'd20);
        for (int i = 0; i < rx.size() && i < sent.size(); i++)
            chk("bp_byte", 32'(rx[i]), 32'(sent[i]));
        cyc(0, A_STA, 0, 0, 1, 32'h2, "bp_status");

        cyc(1, A_CYC, 32'hFFFF_FFFE, 0);
        cyc(0, A_CYC, 0, 0, 1, 32'hFFFF_FFFE, "cycle_0");
        cyc(0, A_CYC, 0, 0, 1, 32'hFFFF_FFFF, "cycle_1");
        cyc(0, A_CYC, 0, 0, 1, 32'h0000_0000, "cycle_2");

        for (int i = 0; i < 3; i++)
            cyc(1, A_CON, 32'(8'h30 + i), 0);
        MemWrite = 1'b0; tx_ready = 1'b0; ALUResult = A_LVL;
        #1; chk("pre_reset_level", ReadData, 32'd3);
        reset = 1'b0;
        #1;
        chk("reset_mid_tx_valid", 32'(tx_valid), 32'h0);
        chk("reset_mid_level", ReadData, 32'h0);
        ALUResult = A_CYC;
        #1; chk("reset_mid_cycle", ReadData, 32'h0);
        reset = 1'b1;
        q.delete();
        ovf_m = 1'b0;
        cyc_m = '0;
        cyc(0, 32'h10, 0, 0, 1, 32'hCAFE_F00D, "ram_after_reset");
        cyc(0, A_CYC, 0, 0, 1, 32'h1, "cycle_after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
